// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg
//   Shared definitions for the pipeline hazard controller: FSM state codes,
//   PC mux encodings and stage-register bit indices. The `define block is
//   include-guarded so other units can pick up the raw constants; the
//   package wraps them in typed form for RTL use.
`ifndef PIPE_HAZARD_CTRL_DEFS
`define PIPE_HAZARD_CTRL_DEFS
`define PHC_ST_IDLE       2'd0
`define PHC_ST_DRAIN      2'd1
`define PHC_ST_PUSH       2'd2
`define PHC_ST_VECTOR     2'd3
`define PHC_PC_SEL_SEQ    2'b00
`define PHC_PC_SEL_BRANCH 2'b01
`define PHC_PC_SEL_VECTOR 2'b10
`define PHC_IFID          0
`define PHC_IDEX          1
`define PHC_EXMEM         2
`define PHC_MEMWB         3
`endif

package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = `PHC_ST_IDLE,
    ST_DRAIN  = `PHC_ST_DRAIN,
    ST_PUSH   = `PHC_ST_PUSH,
    ST_VECTOR = `PHC_ST_VECTOR
  } state_e;

  localparam logic [1:0] PC_SEL_SEQ    = `PHC_PC_SEL_SEQ;
  localparam logic [1:0] PC_SEL_BRANCH = `PHC_PC_SEL_BRANCH;
  localparam logic [1:0] PC_SEL_VECTOR = `PHC_PC_SEL_VECTOR;

  localparam int IFID  = `PHC_IFID;
  localparam int IDEX  = `PHC_IDEX;
  localparam int EXMEM = `PHC_EXMEM;
  localparam int MEMWB = `PHC_MEMWB;

  // Down-counter width: clog2(max(drain, push)) + 1.
  function automatic int cnt_width(input int drain_cycles, input int push_cycles);
    int m;
    m = (drain_cycles > push_cycles) ? drain_cycles : push_cycles;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// load_use_detect
//   Combinational load-use comparator: flags when the instruction in ID
//   reads a register that the load currently in EX is about to write.
//   Kept separate so the forwarding unit can reuse the same comparator.
// Ports:
//   id_rs1/id_rs2           source register addresses of the ID instruction
//   id_rs1_used/id_rs2_used ID instruction actually reads that source
//   ex_mem_read             EX instruction is a load
//   ex_rd                   destination register of the EX instruction
//   lu                      load-use hazard present this cycle
module load_use_detect #(
  parameter int REG_ADDR_W = 3
) (
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  lu
);

  assign lu = ex_mem_read &
              ((id_rs1_used & (id_rs1 == ex_rd)) |
               (id_rs2_used & (id_rs2 == ex_rd)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Stall/flush and PC control for the 5-stage 16-bit pipeline. Resolves
//   load-use hazards, taken-branch flushes and data-memory waits, and
//   sequences interrupt entry as DRAIN -> PUSH -> VECTOR.
//   All control outputs are combinational from the FSM state and inputs;
//   the only flops are the state and a down-counter.
// Ports:
//   clk, reset_n        clock (rising edge), async active-low reset
//   id_*                ID-stage source registers and their use flags
//   ex_mem_read, ex_rd  EX-stage load flag and destination
//   ex_branch_taken     branch resolved taken in EX
//   mem_busy            data memory not ready, freeze the whole pipe
//   int_req             level interrupt request, held until int_ack
//   stall, flush        per stage-register hold / sync zero (bit0 IF/ID)
//   pc_write, pc_sel    PC load enable and source select
//   int_push            MEM stage pushes return PC/flags this cycle
//   int_ack             one-cycle acknowledge, vector loads this edge
//   busy                FSM not in IDLE
//   dbg_state, dbg_cnt  FSM state and down-counter, for observation only
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter  int REG_ADDR_W   = 3,
  parameter  int DRAIN_CYCLES = 3,
  parameter  int PUSH_CYCLES  = 2,
  localparam int CNT_W        = cnt_width(DRAIN_CYCLES, PUSH_CYCLES)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_branch_taken,
  input  logic                  mem_busy,
  input  logic                  int_req,
  output logic [3:0]            stall,
  output logic [3:0]            flush,
  output logic                  pc_write,
  output logic [1:0]            pc_sel,
  output logic                  int_push,
  output logic                  int_ack,
  output logic                  busy,
  output logic [1:0]            dbg_state,
  output logic [CNT_W-1:0]      dbg_cnt
);

  localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] PUSH_INIT  = CNT_W'(PUSH_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu;
  logic             drain_step;

  load_use_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_load_use_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .lu          (lu)
  );

  always_comb begin
    stall      = 4'b0000;
    flush      = 4'b0000;
    pc_write   = 1'b0;
    pc_sel     = PC_SEL_SEQ;
    int_push   = 1'b0;
    int_ack    = 1'b0;
    busy       = 1'b0;
    drain_step = 1'b0;
    state_d    = state_q;
    cnt_d      = cnt_q;

    // Outputs are forced quiet for as long as reset is held, not just
    // after the flops clear.
    if (reset_n) begin
      busy = (state_q != ST_IDLE);
      if (mem_busy) begin
        // Whole pipe freezes; FSM and counter hold, no push/ack.
        stall = 4'b1111;
      end else begin
        case (state_q)
          ST_IDLE: begin
            pc_write = 1'b1;
            if (ex_branch_taken) begin
              // Branch wins over lu: the dependent instruction is discarded.
              flush[IFID] = 1'b1;
              flush[IDEX] = 1'b1;
              pc_sel      = PC_SEL_BRANCH;
            end else if (lu) begin
              stall[IFID] = 1'b1;
              flush[IDEX] = 1'b1;
              pc_write    = 1'b0;
            end else if (int_req) begin
              // Accept cycle itself looks normal; draining starts next cycle.
              state_d = ST_DRAIN;
              cnt_d   = DRAIN_INIT;
            end
          end
          ST_DRAIN: begin
            flush[IFID] = 1'b1;
            if (ex_branch_taken) begin
              // Branch target becomes the return PC.
              flush[IDEX] = 1'b1;
              pc_sel      = PC_SEL_BRANCH;
              pc_write    = 1'b1;
              drain_step  = 1'b1;
            end else if (lu) begin
              // stall[0] dominates flush[0] at the IF/ID register; the
              // drain window is extended by not counting this cycle.
              stall[IFID] = 1'b1;
              flush[IDEX] = 1'b1;
            end else begin
              drain_step = 1'b1;
            end
            if (drain_step) begin
              if (cnt_q == '0) begin
                state_d = ST_PUSH;
                cnt_d   = PUSH_INIT;
              end else begin
                cnt_d = cnt_q - CNT_W'(1);
              end
            end
          end
          ST_PUSH: begin
            int_push    = 1'b1;
            flush[IFID] = 1'b1;
            if (cnt_q == '0) begin
              state_d = ST_VECTOR;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
          ST_VECTOR: begin
            pc_sel      = PC_SEL_VECTOR;
            pc_write    = 1'b1;
            int_ack     = 1'b1;
            flush[IFID] = 1'b1;
            state_d     = ST_IDLE;
          end
          default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dbg_state = state_q;
  assign dbg_cnt   = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
//   Directed bench for pipe_hazard_ctrl. Inputs change 1ns after the rising
//   edge; outputs are sampled on the falling edge. All outputs are packed
//   into one 14-bit word {stall, flush, pc_write, pc_sel, int_push, int_ack,
//   busy} and compared against hand-built expected words.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] id_rs1, id_rs2, ex_rd;
  logic       id_rs1_used, id_rs2_used, ex_mem_read;
  logic       ex_branch_taken, mem_busy, int_req;
  logic [3:0] stall, flush;
  logic       pc_write, int_push, int_ack, busy;
  logic [1:0] pc_sel, dbg_state;
  logic [2:0] dbg_cnt;
  logic [13:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rs1_used     (id_rs1_used),
    .id_rs2_used     (id_rs2_used),
    .ex_mem_read     (ex_mem_read),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .mem_busy        (mem_busy),
    .int_req         (int_req),
    .stall           (stall),
    .flush           (flush),
    .pc_write        (pc_write),
    .pc_sel          (pc_sel),
    .int_push        (int_push),
    .int_ack         (int_ack),
    .busy            (busy),
    .dbg_state       (dbg_state),
    .dbg_cnt         (dbg_cnt)
  );

  assign obs = {stall, flush, pc_write, pc_sel, int_push, int_ack, busy};

  function automatic logic [13:0] mk(input logic [3:0] s, input logic [3:0] f,
                                     input logic pw, input logic [1:0] ps,
                                     input logic push, input logic ack,
                                     input logic bz);
    return {s, f, pw, ps, push, ack, bz};
  endfunction

  // Expected output words.
  logic [13:0] w_zero, w_normal, w_lu, w_br, w_mb_idle, w_mb_busy;
  logic [13:0] w_drain, w_push, w_vec, w_drain_lu, w_drain_br;

  initial begin
    w_zero     = 14'd0;
    w_normal   = mk(4'b0000, 4'b0000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    w_lu       = mk(4'b0001, 4'b0010, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    w_br       = mk(4'b0000, 4'b0011, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
    w_mb_idle  = mk(4'b1111, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    w_mb_busy  = mk(4'b1111, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    w_drain    = mk(4'b0000, 4'b0001, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    w_push     = mk(4'b0000, 4'b0001, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
    w_vec      = mk(4'b0000, 4'b0001, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1);
    w_drain_lu = mk(4'b0001, 4'b0011, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    w_drain_br = mk(4'b0000, 4'b0011, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
  end

  task automatic set_idle();
    id_rs1 = 3'd0; id_rs2 = 3'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_mem_read = 1'b0; ex_rd = 3'd0; ex_branch_taken = 1'b0;
    mem_busy = 1'b0; int_req = 1'b0;
  endtask

  task automatic set_lu_r2();
    ex_mem_read = 1'b1; ex_rd = 3'd2; id_rs1 = 3'd2; id_rs1_used = 1'b1;
    id_rs2 = 3'd5; id_rs2_used = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_idle();
    reset_n = 1'b0;
    int_req = 1'b1; mem_busy = 1'b1; ex_branch_taken = 1'b1;
    tick();
    tick();
    @(negedge clk);
    n_checks++;
    if (obs !== w_zero) begin n_fail++; $display("FAIL reset_outputs: got %b exp %b", obs, w_zero); end
    n_checks++;
    if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d exp 0", dbg_state); end
    tick();
    set_idle();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_normal();
    set_idle();
    @(negedge clk);
    n_checks++;
    if (obs !== w_normal) begin n_fail++; $display("FAIL normal_idle: got %b exp %b", obs, w_normal); end
    tick();
    // Load in EX to r3, ID reads r2 (used) and r3 (not used): no hazard.
    ex_mem_read = 1'b1; ex_rd = 3'd3; id_rs1 = 3'd2; id_rs1_used = 1'b1;
    id_rs2 = 3'd3; id_rs2_used = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs !== w_normal) begin n_fail++; $display("FAIL normal_unused_rs2: got %b exp %b", obs, w_normal); end
    tick();
    // Matching register but EX is not a load.
    ex_mem_read = 1'b0; ex_rd = 3'd2;
    @(negedge clk);
    n_checks++;
    if (obs !== w_normal) begin n_fail++; $display("FAIL normal_not_load: got %b exp %b", obs, w_normal); end
    tick();
  endtask

  task automatic test_load_use();
    set_idle();
    set_lu_r2();
    @(negedge clk);
    n_checks++;
    if (obs !== w_lu) begin n_fail++; $display("FAIL lu_rs1: got %b exp %b", obs, w_lu); end
    tick();
    // Bubble now in EX: hazard gone.
    ex_mem_read = 1'b0; ex_rd = 3'd0;
    @(negedge clk);
    n_checks++;
    if (obs !== w_normal) begin n_fail++; $display("FAIL lu_next_normal: got %b exp %b", obs, w_normal); end
    tick();
    // Hazard through rs2 only, r7.
    set_idle();
    ex_mem_read = 1'b1; ex_rd = 3'd7; id_rs1 = 3'd7; id_rs1_used = 1'b0;
    id_rs2 = 3'd7; id_rs2_used = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs !== w_lu) begin n_fail++; $display("FAIL lu_rs2: got %b exp %b", obs, w_lu); end
    tick();
    set_idle();
  endtask

  task automatic test_branch_priority();
    set_idle();
    set_lu_r2();
    ex_branch_taken = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs !== w_br) begin n_fail++; $display("FAIL branch_over_lu: got %b exp %b", obs, w_br); end
    tick();
    mem_busy = 1'b1;
    int_req  = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs !== w_mb_idle) begin n_fail++; $display("FAIL mem_busy_over_branch: got %b exp %b", obs, w_mb_idle); end
    tick();
    // int_req was masked by mem_busy: still IDLE.
    set_idle();
    @(negedge clk);
    n_checks++;
    if (dbg_state !== 2'd0 || obs !== w_normal) begin
      n_fail++; $display("FAIL mem_busy_defers_int: got state %0d out %b exp state 0 out %b", dbg_state, obs, w_normal);
    end
    tick();
  endtask

  task automatic test_int_sequence();
    logic [13:0] exp_seq [8];
    int busy_cycles;
    exp_seq[0] = w_normal; exp_seq[1] = w_drain; exp_seq[2] = w_drain;
    exp_seq[3] = w_drain;  exp_seq[4] = w_push;  exp_seq[5] = w_push;
    exp_seq[6] = w_vec;    exp_seq[7] = w_normal;
    busy_cycles = 0;
    set_idle();
    int_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) int_req = 1'b0;
      @(negedge clk);
      if (busy === 1'b1) busy_cycles++;
      n_checks++;
      if (obs !== exp_seq[i]) begin n_fail++; $display("FAIL int_seq_cycle%0d: got %b exp %b", i, obs, exp_seq[i]); end
      tick();
    end
    n_checks++;
    if (busy_cycles != 6) begin n_fail++; $display("FAIL int_busy_len: got %0d exp 6", busy_cycles); end
  endtask

  task automatic test_mem_busy_drain();
    set_idle();
    int_req = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs !== w_normal) begin n_fail++; $display("FAIL mb_accept: got %b exp %b", obs, w_normal); end
    tick();
    @(negedge clk);
    n_checks++;
    if (obs !== w_drain || dbg_cnt !== 3'd2) begin n_fail++; $display("FAIL mb_drain_cnt2: got %b cnt %0d exp %b cnt 2", obs, dbg_cnt, w_drain); end
    tick();
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== w_mb_busy || dbg_cnt !== 3'd1 || dbg_state !== 2'd1) begin
        n_fail++; $display("FAIL mb_freeze%0d: got %b cnt %0d st %0d exp %b cnt 1 st 1", i, obs, dbg_cnt, dbg_state, w_mb_busy);
      end
      tick();
    end
    mem_busy = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs !== w_drain || dbg_cnt !== 3'd1) begin n_fail++; $display("FAIL mb_resume_cnt1: got %b cnt %0d exp %b cnt 1", obs, dbg_cnt, w_drain); end
    tick();
    @(negedge clk);
    n_checks++;
    if (obs !== w_drain || dbg_cnt !== 3'd0) begin n_fail++; $display("FAIL mb_resume_cnt0: got %b cnt %0d exp %b cnt 0", obs, dbg_cnt, w_drain); end
    tick();
    @(negedge clk);
    n_checks++;
    if (obs !== w_push) begin n_fail++; $display("FAIL mb_push_entry: got %b exp %b", obs, w_push); end
    tick();
    tick();
    // VECTOR state, but memory stalls: ack must be held off.
    mem_busy = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs !== w_mb_busy || dbg_state !== 2'd3) begin n_fail++; $display("FAIL mb_hold_ack: got %b st %0d exp %b st 3", obs, dbg_state, w_mb_busy); end
    tick();
    mem_busy = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs !== w_vec) begin n_fail++; $display("FAIL mb_vector: got %b exp %b", obs, w_vec); end
    tick();
    int_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs !== w_normal) begin n_fail++; $display("FAIL mb_back_idle: got %b exp %b", obs, w_normal); end
    tick();
  endtask

  task automatic test_defer_and_reset();
    int ack_at;
    set_idle();
    int_req = 1'b1;
    ex_branch_taken = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs !== w_br) begin n_fail++; $display("FAIL defer_branch_out: got %b exp %b", obs, w_br); end
    tick();
    ex_branch_taken = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dbg_state !== 2'd0 || obs !== w_normal) begin n_fail++; $display("FAIL defer_still_idle: got st %0d out %b exp st 0 out %b", dbg_state, obs, w_normal); end
    tick();
    // Load-use inside DRAIN: counter holds.
    set_lu_r2();
    @(negedge clk);
    n_checks++;
    if (obs !== w_drain_lu || dbg_cnt !== 3'd2) begin n_fail++; $display("FAIL drain_lu: got %b cnt %0d exp %b cnt 2", obs, dbg_cnt, w_drain_lu); end
    tick();
    ex_mem_read = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs !== w_drain || dbg_cnt !== 3'd2) begin n_fail++; $display("FAIL drain_lu_hold: got %b cnt %0d exp %b cnt 2", obs, dbg_cnt, w_drain); end
    tick();
    // Taken branch inside DRAIN: counter still decrements.
    ex_branch_taken = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs !== w_drain_br || dbg_cnt !== 3'd1) begin n_fail++; $display("FAIL drain_branch: got %b cnt %0d exp %b cnt 1", obs, dbg_cnt, w_drain_br); end
    tick();
    ex_branch_taken = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dbg_cnt !== 3'd0 || obs !== w_drain) begin n_fail++; $display("FAIL drain_branch_dec: got %b cnt %0d exp %b cnt 0", obs, dbg_cnt, w_drain); end
    tick();
    @(negedge clk);
    n_checks++;
    if (obs !== w_push) begin n_fail++; $display("FAIL pre_reset_push: got %b exp %b", obs, w_push); end
    // Asynchronous reset in the middle of PUSH.
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== w_zero || dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_mid_push: got %b st %0d exp %b st 0", obs, dbg_state, w_zero); end
    tick();
    @(negedge clk);
    n_checks++;
    if (obs !== w_zero) begin n_fail++; $display("FAIL reset_held_no_ack: got %b exp %b", obs, w_zero); end
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs !== w_normal) begin n_fail++; $display("FAIL reentry_accept: got %b exp %b", obs, w_normal); end
    tick();
    @(negedge clk);
    n_checks++;
    if (obs !== w_drain || dbg_cnt !== 3'd2) begin n_fail++; $display("FAIL reentry_drain: got %b cnt %0d exp %b cnt 2", obs, dbg_cnt, w_drain); end
    ack_at = -1;
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      if (int_ack === 1'b1) begin
        ack_at = i;
        break;
      end
    end
    n_checks++;
    if (ack_at != 4) begin n_fail++; $display("FAIL reentry_ack_timing: got cycle %0d exp 4", ack_at); end
    tick();
    int_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs !== w_normal) begin n_fail++; $display("FAIL reentry_idle: got %b exp %b", obs, w_normal); end
    tick();
  endtask

  initial begin
    set_idle();
    test_reset();
    test_normal();
    test_load_use();
    test_branch_priority();
    test_int_sequence();
    test_mem_busy_drain();
    test_defer_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
